// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e    - serial frame FSM states
//   UART_DATA_BITS  - data bits per character (8N1 framing)
//   UART_START_BIT  - line level of the start bit
//   UART_STOP_BIT   - line level of the stop bit (also the idle level)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic        UART_START_BIT = 1'b0;
    localparam logic        UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO used to queue characters for uart_tx.
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset (empties the FIFO)
//   push   - write din (ignored while full)
//   din    - write data
//   pop    - discard the head entry (ignored while empty)
//   dout   - head entry, valid while !empty
//   full   - DEPTH entries held
//   empty  - no entries held
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter.
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset; aborts any frame, line goes high
//   bc      - baud divisor, one bit period = bc+1 clk cycles (sampled per frame)
//   ch_vld  - upstream character valid
//   ch      - character to send, LSB first
//   ch_rdy  - character accepted on an edge where ch_vld && ch_rdy
//   tx      - serial line, idle high, driven from a flop
//   busy    - frame in progress or a character waiting
// Build option: define UART_TX_FIFO_EN to queue characters in a FIFO_DEPTH
// entry FIFO (frames then run back to back); otherwise a single holding
// register is used and each frame needs a fresh handshake.
module uart_tx #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bc,
    input  logic        ch_vld,
    input  logic [7:0]  ch,
    output logic        ch_rdy,
    output logic        tx,
    output logic        busy
);

    import uart_pkg::*;

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_state_e                state_q, state_d;
    logic [15:0]                cnt_q, cnt_d;
    logic [15:0]                bc_q, bc_d;
    logic [2:0]                 bit_q, bit_d;
    logic [UART_DATA_BITS-1:0]  data_q, data_d;
    logic                       tx_q, tx_d;

    logic                       avail;
    logic [UART_DATA_BITS-1:0]  next_ch;
    logic                       pop;
    logic                       load;

`ifdef UART_TX_FIFO_EN
    logic fifo_full, fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ch_vld),
        .din   (ch),
        .pop   (pop),
        .dout  (next_ch),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ch_rdy = !fifo_full;
    assign avail  = !fifo_empty;
`else
    logic [UART_DATA_BITS-1:0] hold_q, hold_d;
    logic                      hold_vld_q, hold_vld_d;
    logic                      ch_rdy_q, ch_rdy_d;

    // Ready only while the FSM will be idle with nothing held, so it drops
    // on the accepting edge and stays low for the whole frame.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (pop) begin
            hold_vld_d = 1'b0;
        end
        if (ch_vld && ch_rdy_q) begin
            hold_d     = ch;
            hold_vld_d = 1'b1;
        end
        ch_rdy_d = (state_d == IDLE) && !hold_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            ch_rdy_q   <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            ch_rdy_q   <= ch_rdy_d;
        end
    end

    assign ch_rdy  = ch_rdy_q;
    assign avail   = hold_vld_q;
    assign next_ch = hold_q;
`endif

    // Every state holds its bit while cnt counts bc..0; at zero the next
    // bit is presented and cnt reloads from the per-frame bc copy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bc_d    = bc_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = UART_STOP_BIT;
                load = avail;
            end
            START: begin
                if (cnt_q == '0) begin
                    cnt_d   = bc_q;
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = bc_q;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = UART_STOP_BIT;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_d];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (avail) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = UART_STOP_BIT;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = UART_STOP_BIT;
            end
        endcase
        // Frame start: take the next character and freeze bc for this frame.
        if (load) begin
            state_d = START;
            cnt_d   = bc;
            bc_d    = bc;
            data_d  = next_ch;
            tx_d    = UART_START_BIT;
        end
        pop = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bc_q    <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= UART_STOP_BIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bc_q    <= bc_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) || avail;

endmodule
